// File: rtl/aclu_sequencer.sv
// aclu_sequencer: microsequencer that fetches 8-bit words from the program ROM
// and drives the ACLU control lines, branching on the latched carry/zero flags.
module aclu_sequencer #(
  parameter int AW = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic          STEP_MODE,
  input  logic          STEP,
  input  logic [7:0]    INSTR,
  input  logic          C,
  input  logic          ZERO,
  output logic [AW-1:0] PC,
  output logic          ENABLE,
  output logic          AC1,
  output logic          AC2,
  output logic [2:0]    SEL,
  output logic [3:0]    IMM,
  output logic          BUSY,
  output logic          DONE
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_WRITE,
    S_WAIT,
    S_HALT
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_pc;
  logic [7:0]    r_ir;
  logic          r_cf;
  logic          r_zf;
  logic          r_enable;
  logic          r_ac1;
  logic          r_ac2;
  logic [2:0]    r_sel;
  logic [3:0]    r_imm;
  logic          r_busy;
  logic          r_done;

  logic [3:0]    w_opcode;
  logic [AW-1:0] w_pcInc;
  logic [AW-1:0] w_target;
  state_t        w_after;

  assign w_opcode = r_ir[7:4];
  assign w_pcInc  = r_pc + AW'(1);
  assign w_target = AW'(r_ir[3:0]);
  assign w_after  = STEP_MODE ? S_WAIT : S_FETCH;

  // Outputs are registered for the state being entered, so every datapath
  // strobe defaults low and is only raised on the transition into its state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_ir     <= '0;
      r_cf     <= 1'b0;
      r_zf     <= 1'b0;
      r_enable <= 1'b0;
      r_ac1    <= 1'b0;
      r_ac2    <= 1'b0;
      r_sel    <= '0;
      r_imm    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_enable <= 1'b0;
      r_ac1    <= 1'b0;
      r_ac2    <= 1'b0;
      r_sel    <= '0;
      r_imm    <= '0;
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_state <= S_FETCH;
            r_pc    <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        // IR is still loading here, so EXEC outputs decode straight from INSTR.
        S_FETCH: begin
          r_ir    <= INSTR;
          r_state <= S_EXEC;
          if (!INSTR[7]) begin
            r_ac1 <= 1'b1;
            r_sel <= INSTR[6:4];
            r_imm <= INSTR[3:0];
          end else if (INSTR[7:4] == 4'hB) begin
            r_ac2 <= 1'b1;
          end
        end
        S_EXEC: begin
          if (!w_opcode[3]) begin
            r_state  <= S_WRITE;
            r_enable <= 1'b1;
            r_ac1    <= 1'b1;
            r_sel    <= r_ir[6:4];
            r_imm    <= r_ir[3:0];
          end else if (w_opcode == 4'hF) begin
            r_state <= S_HALT;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= w_after;
            case (w_opcode)
              4'h8:    r_pc <= w_target;
              4'h9:    r_pc <= r_cf ? w_target : w_pcInc;
              4'hA:    r_pc <= r_zf ? w_target : w_pcInc;
              default: r_pc <= w_pcInc;
            endcase
          end
        end
        S_WRITE: begin
          r_cf    <= C;
          r_zf    <= ZERO;
          r_pc    <= w_pcInc;
          r_state <= w_after;
        end
        S_WAIT: begin
          if (STEP || !STEP_MODE) begin
            r_state <= S_FETCH;
          end
        end
        S_HALT: begin
          if (START) begin
            r_state <= S_FETCH;
            r_pc    <= '0;
            r_cf    <= 1'b0;
            r_zf    <= 1'b0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign PC     = r_pc;
  assign ENABLE = r_enable;
  assign AC1    = r_ac1;
  assign AC2    = r_ac2;
  assign SEL    = r_sel;
  assign IMM    = r_imm;
  assign BUSY   = r_busy;
  assign DONE   = r_done;

endmodule

// File: tb/tb_aclu_sequencer.sv
// tb_aclu_sequencer: directed scenarios plus random programs checked against
// an instruction-level model of the sequencer's per-cycle outputs.
module tb_aclu_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       START = 1'b0;
  logic       STEP_MODE = 1'b0;
  logic       STEP = 1'b0;
  logic       C = 1'b0;
  logic       ZERO = 1'b0;
  logic [7:0] INSTR;
  logic [3:0] PC;
  logic       ENABLE, AC1, AC2, BUSY, DONE;
  logic [2:0] SEL;
  logic [3:0] IMM;

  logic [7:0]  mem [16];
  logic [15:0] expQ [$];
  logic [3:0]  mPc;
  logic        mCf, mZf, mHalted;
  int          vectors = 0;
  int          miscompares = 0;

  aclu_sequencer #(.AW(4)) dut (
    .CLK(CLK), .RST(RST), .START(START), .STEP_MODE(STEP_MODE), .STEP(STEP),
    .INSTR(INSTR), .C(C), .ZERO(ZERO), .PC(PC), .ENABLE(ENABLE), .AC1(AC1),
    .AC2(AC2), .SEL(SEL), .IMM(IMM), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  assign INSTR = mem[PC];
  wire [15:0] obs = {PC, ENABLE, AC1, AC2, SEL, IMM, BUSY, DONE};

  function automatic logic [15:0] vec(input logic [3:0] pc, input logic en, a1, a2,
                                      input logic [2:0] sel, input logic [3:0] imm,
                                      input logic busy, done);
    return {pc, en, a1, a2, sel, imm, busy, done};
  endfunction

  function automatic logic [15:0] fetchVec(input logic [3:0] pc);
    return vec(pc, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b1, 1'b0);
  endfunction

  function automatic logic [15:0] haltVec(input logic [3:0] pc);
    return vec(pc, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic doReset();
    RST = 1'b0;
    START = 1'b0;
    STEP = 1'b0;
    tick();
    RST = 1'b1;
  endtask

  task automatic startProgram();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  // Expands one instruction into its expected cycle trace: FETCH, EXEC,
  // WRITE for ALU ops, then the requested number of WAIT cycles.
  task automatic modelInstr(input int waits, input logic c, input logic z);
    logic [7:0] ins;
    logic [3:0] op, opd;
    ins = mem[mPc];
    op  = ins[7:4];
    opd = ins[3:0];
    expQ.push_back(fetchVec(mPc));
    if (op < 4'h8) begin
      expQ.push_back(vec(mPc, 1'b0, 1'b1, 1'b0, op[2:0], opd, 1'b1, 1'b0));
      expQ.push_back(vec(mPc, 1'b1, 1'b1, 1'b0, op[2:0], opd, 1'b1, 1'b0));
      mCf = c;
      mZf = z;
      mPc = mPc + 4'd1;
    end else begin
      expQ.push_back(vec(mPc, 1'b0, 1'b0, op == 4'hB, 3'd0, 4'd0, 1'b1, 1'b0));
      case (op)
        4'h8:    mPc = opd;
        4'h9:    mPc = mCf ? opd : mPc + 4'd1;
        4'hA:    mPc = mZf ? opd : mPc + 4'd1;
        4'hF:    mHalted = 1'b1;
        default: mPc = mPc + 4'd1;
      endcase
    end
    if (!mHalted) repeat (waits) expQ.push_back(fetchVec(mPc));
  endtask

  task automatic test_reset();
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      START = 1'($urandom); STEP = 1'($urandom); STEP_MODE = 1'($urandom);
      C = 1'($urandom); ZERO = 1'($urandom);
      #3;
      vectors++;
      if (obs !== 16'h0) begin
        miscompares++;
        $display("[TB] FAIL reset_held %0d: got %h expected %h", i, obs, 16'h0);
      end
      tick();
    end
    START = 1'b0; STEP = 1'b0; STEP_MODE = 1'b0;
    RST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (obs !== 16'h0) begin
        miscompares++;
        $display("[TB] FAIL reset_idle %0d: got %h expected %h", i, obs, 16'h0);
      end
    end
  endtask

  task automatic test_alu();
    logic [15:0] exp [4];
    for (int i = 0; i < 16; i++) mem[i] = 8'hC0;
    mem[0] = 8'h25;
    STEP_MODE = 1'b0;
    doReset();
    startProgram();
    exp[0] = fetchVec(4'd0);
    exp[1] = vec(4'd0, 1'b0, 1'b1, 1'b0, 3'b010, 4'b0101, 1'b1, 1'b0);
    exp[2] = vec(4'd0, 1'b1, 1'b1, 1'b0, 3'b010, 4'b0101, 1'b1, 1'b0);
    exp[3] = fetchVec(4'd1);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (obs !== exp[i]) begin
        miscompares++;
        $display("[TB] FAIL alu cycle %0d: got %h expected %h", i, obs, exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_branch();
    logic [3:0] pcs [7] = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd9, 4'd15, 4'd0};
    int         cyc [6] = '{3, 2, 3, 2, 2, 3};
    logic       zs  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       cs  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 16; i++) mem[i] = 8'hC0;
    mem[0] = 8'h31; mem[1] = 8'hA7; mem[7] = 8'h40;
    mem[8] = 8'hAC; mem[9] = 8'h9F; mem[15] = 8'h11;
    STEP_MODE = 1'b0;
    doReset();
    startProgram();
    for (int i = 0; i < 7; i++) begin
      if (i < 6) begin
        C = cs[i];
        ZERO = zs[i];
      end
      vectors++;
      if (obs !== fetchVec(pcs[i])) begin
        miscompares++;
        $display("[TB] FAIL branch fetch %0d: got %h expected %h", i, obs, fetchVec(pcs[i]));
      end
      if (i < 6) repeat (cyc[i]) tick();
    end
  endtask

  task automatic test_halt();
    for (int i = 0; i < 16; i++) mem[i] = 8'hC0;
    mem[1] = 8'hD0; mem[2] = 8'hE0; mem[3] = 8'hF0;
    STEP_MODE = 1'b0;
    doReset();
    startProgram();
    repeat (8) tick();
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (obs !== haltVec(4'd3)) begin
        miscompares++;
        $display("[TB] FAIL halt_hold %0d: got %h expected %h", i, obs, haltVec(4'd3));
      end
      tick();
    end
    START = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) tick(); else repeat (2) tick();
      vectors++;
      if (obs !== fetchVec(4'(i))) begin
        miscompares++;
        $display("[TB] FAIL halt_restart %0d: got %h expected %h", i, obs, fetchVec(4'(i)));
      end
    end
    START = 1'b0;
  endtask

  task automatic test_step();
    logic [15:0] exp [13];
    logic        stp [13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        sm  [13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                              1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 16; i++) mem[i] = 8'hC0;
    mem[0] = 8'h13; mem[1] = 8'hB0; mem[2] = 8'hF0;
    exp[0]  = fetchVec(4'd0);
    exp[1]  = vec(4'd0, 1'b0, 1'b1, 1'b0, 3'd1, 4'd3, 1'b1, 1'b0);
    exp[2]  = vec(4'd0, 1'b1, 1'b1, 1'b0, 3'd1, 4'd3, 1'b1, 1'b0);
    exp[3]  = fetchVec(4'd1);
    exp[4]  = fetchVec(4'd1);
    exp[5]  = fetchVec(4'd1);
    exp[6]  = fetchVec(4'd1);
    exp[7]  = vec(4'd1, 1'b0, 1'b0, 1'b1, 3'd0, 4'd0, 1'b1, 1'b0);
    exp[8]  = fetchVec(4'd2);
    exp[9]  = fetchVec(4'd2);
    exp[10] = fetchVec(4'd2);
    exp[11] = fetchVec(4'd2);
    exp[12] = haltVec(4'd2);
    STEP_MODE = 1'b1;
    doReset();
    startProgram();
    for (int i = 0; i < 13; i++) begin
      STEP = stp[i];
      STEP_MODE = sm[i];
      vectors++;
      if (obs !== exp[i]) begin
        miscompares++;
        $display("[TB] FAIL step cycle %0d: got %h expected %h", i, obs, exp[i]);
      end
      tick();
    end
    STEP = 1'b0;
    STEP_MODE = 1'b0;
  endtask

  task automatic test_midreset();
    logic [15:0] wr;
    for (int i = 0; i < 16; i++) mem[i] = 8'hC0;
    mem[0] = 8'h25;
    STEP_MODE = 1'b0;
    doReset();
    startProgram();
    repeat (2) tick();
    wr = vec(4'd0, 1'b1, 1'b1, 1'b0, 3'd2, 4'd5, 1'b1, 1'b0);
    vectors++;
    if (obs !== wr) begin
      miscompares++;
      $display("[TB] FAIL midreset_write: got %h expected %h", obs, wr);
    end
    #2 RST = 1'b0;
    #1;
    vectors++;
    if (obs !== 16'h0) begin
      miscompares++;
      $display("[TB] FAIL midreset_async: got %h expected %h", obs, 16'h0);
    end
    tick();
    RST = 1'b1;
    startProgram();
    vectors++;
    if (obs !== fetchVec(4'd0)) begin
      miscompares++;
      $display("[TB] FAIL midreset_restart: got %h expected %h", obs, fetchVec(4'd0));
    end
    tick();
    vectors++;
    if (obs !== vec(4'd0, 1'b0, 1'b1, 1'b0, 3'd2, 4'd5, 1'b1, 1'b0)) begin
      miscompares++;
      $display("[TB] FAIL midreset_exec: got %h expected %h", obs,
               vec(4'd0, 1'b0, 1'b1, 1'b0, 3'd2, 4'd5, 1'b1, 1'b0));
    end
  endtask

  // Random programs with random flags, and START/STEP toggled where they must be ignored.
  task automatic test_random(input int nProg, input logic stepMode);
    int          total, waits, n;
    logic [15:0] e;
    for (int p = 0; p < nProg; p++) begin
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      STEP_MODE = stepMode;
      doReset();
      startProgram();
      mPc = 4'd0; mCf = 1'b0; mZf = 1'b0; mHalted = 1'b0;
      n = 0;
      while (!mHalted && n < 40) begin
        C = 1'($urandom);
        ZERO = 1'($urandom);
        waits = stepMode ? int'($urandom_range(1, 3)) : 0;
        modelInstr(waits, C, ZERO);
        if (mHalted) waits = 0;
        total = expQ.size();
        for (int i = 0; i < total; i++) begin
          e = expQ.pop_front();
          START = 1'($urandom);
          STEP = (i >= total - waits) ? (i == total - 1) : 1'($urandom);
          vectors++;
          if (obs !== e) begin
            miscompares++;
            $display("[TB] FAIL random prog %0d instr %0d: got %h expected %h", p, n, obs, e);
          end
          tick();
        end
        n++;
      end
      START = 1'b0;
      STEP = 1'b0;
      if (mHalted) begin
        for (int i = 0; i < 2; i++) begin
          vectors++;
          if (obs !== haltVec(mPc)) begin
            miscompares++;
            $display("[TB] FAIL random halt prog %0d: got %h expected %h", p, obs, haltVec(mPc));
          end
          tick();
        end
      end
    end
    STEP_MODE = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_alu();
    test_branch();
    test_halt();
    test_step();
    test_midreset();
    test_random(8, 1'b0);
    test_random(4, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule

// File: doc/aclu_sequencer.md
# aclu_sequencer

Microsequencer that drives the 4-bit accumulator/ALU datapath (ACLU) from a 16-word external program memory. It fetches 8-bit instructions, decodes them into the ACLU control lines (ENABLE, AC1, AC2, SEL) and the immediate bus (IN), and branches on the ACLU carry and zero flags. It sits between the program ROM and the ACLU and is the only block that drives the ACLU control inputs.

## Interface

- AW, 4, program counter width; the program memory holds 2^AW words.
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- START  input  1  level-sampled; starts a program from PC=0 when in IDLE or HALT.
- STEP_MODE  input  1  1 = pause in WAIT after every instruction.
- STEP  input  1  in WAIT, a sampled 1 advances to the next FETCH.
- INSTR  input  8  program word at address PC; combinational read, valid in the same cycle.
- C  input  1  ACLU carry output.
- ZERO  input  1  ACLU zero output.
- PC  output  AW  program memory address.
- ENABLE  output  1  ACLU accumulator load enable.
- AC1  output  1  ACLU input-buffer enable (IN to ALU).
- AC2  output  1  ACLU output-buffer enable (accumulator to OUT).
- SEL  output  3  ACLU operation select.
- IMM  output  4  immediate operand; drives the ACLU IN bus.
- BUSY  output  1  1 while a program is running, including WAIT.
- DONE  output  1  1 while in HALT.

## Operation

- Instruction layout: INSTR[7:4] is the opcode, INSTR[3:0] is the operand. Latched into IR in FETCH.
- Opcodes:
  - 0x0–0x7 ALU: SEL=opcode[2:0], IMM=operand. SEL semantics belong to the ACLU and are passed through unchanged.
  - 0x8 JMP: PC=operand.
  - 0x9 JC: PC=operand if CF=1, else PC+1.
  - 0xA JZ: PC=operand if ZF=1, else PC+1.
  - 0xB OUT: AC2=1 for one cycle.
  - 0xF HALT.
  - 0xC–0xE: NOP.
- For AW>4, jump targets are zero-extended.
- States: IDLE, FETCH, EXEC, WRITE, WAIT, HALT.
  - IDLE: START=1 → PC=0, FETCH.
  - FETCH: IR←INSTR → EXEC.
  - EXEC, ALU op: AC1=1, SEL and IMM driven → WRITE.
  - EXEC, jump: PC updated, no datapath activity → next.
  - EXEC, OUT: AC2=1 → next.
  - EXEC, NOP: → next.
  - EXEC, HALT: → HALT.
  - WRITE: AC1=1, ENABLE=1, SEL and IMM held. CF←C and ZF←ZERO at the end of the cycle. PC←PC+1 → next.
  - "next" is WAIT if STEP_MODE=1, else FETCH.
  - WAIT: STEP=1 → FETCH. STEP_MODE dropping to 0 while in WAIT also → FETCH.
  - HALT: PC held, DONE=1. START=1 → PC=0, CF=ZF=0, FETCH.
- Invariants:
  - AC1 and AC2 are never 1 in the same cycle.
  - ENABLE=1 only in WRITE.
  - SEL and IMM are 0 outside EXEC and WRITE.
- PC arithmetic is modulo 2^AW; PC+1 at the top address wraps to 0.
- START is ignored outside IDLE and HALT. STEP is ignored outside WAIT.
- CF and ZF change only in WRITE. Jumps, OUT and NOP preserve them.

## Timing

- All control outputs are registered, decoded from next-state, so they change only on CLK edges (or on reset).
- Reset (RST=0): immediately and asynchronously, state=IDLE and every output is 0 (PC, ENABLE, AC1, AC2, SEL, IMM, BUSY, DONE), as are IR, CF and ZF. Reset asserted mid-instruction, including during WRITE, drops ENABLE and AC1 without waiting for a clock edge.
- START sampled 1 at edge n: BUSY=1 and the FETCH state are active after edge n.
- Instruction latencies with STEP_MODE=0:
  - ALU instruction: 3 cycles (FETCH, EXEC, WRITE).
  - Jump, OUT or NOP: 2 cycles.
  - HALT: FETCH, EXEC, then HALT; DONE=1 and BUSY=0 from the first HALT cycle.
- ENABLE is high for exactly one cycle per ALU instruction, and AC1 has already been high for one cycle when ENABLE asserts. This gives the ACLU one full cycle to settle before the accumulator loads.
- C and ZERO are sampled at the WRITE edge and must be valid in that cycle.

## Test plan

- Reset:
  - Stimulus: drive arbitrary inputs with RST=0.
  - Required: all outputs 0.
  - Stimulus: release RST with START=0 for 5 cycles.
  - Required: state stays IDLE and all outputs stay 0.
- ALU instruction:
  - Stimulus: START=1, INSTR=0x25 at PC=0.
  - Required: EXEC cycle has AC1=1, SEL=010, IMM=0101, ENABLE=0. WRITE cycle has AC1=1, ENABLE=1. PC=1 on the next FETCH. AC2=0 throughout.
- Conditional branches:
  - Stimulus: after WRITE with ZERO=1, execute INSTR=0xA7.
  - Required: PC=7 two cycles after FETCH.
  - Stimulus: repeat with ZERO=0.
  - Required: PC=old PC+1.
  - Stimulus: JC with C=1 latched, INSTR=0x9F.
  - Required: PC=15.
  - Stimulus: ALU op at PC=15.
  - Required: PC wraps to 0.
- HALT and restart:
  - Stimulus: INSTR=0xF0 at PC=3.
  - Required: DONE=1, BUSY=0, PC holds 3 for 10 cycles.
  - Stimulus: START=1.
  - Required: PC=0, DONE=0, BUSY=1.
  - Stimulus: START=1 while BUSY=1.
  - Required: no effect.
- Single-step:
  - Stimulus: STEP_MODE=1, run 0x13 then 0xB0.
  - Required: sequencer parks in WAIT after each instruction with BUSY=1 and all control lines 0. Each 1-cycle STEP pulse advances exactly one instruction. The OUT instruction gives AC2=1 for one cycle.
- Mid-operation reset:
  - Stimulus: assert RST=0 between edges during WRITE.
  - Required: ENABLE and AC1 fall before the next CLK edge, and PC=0.
  - Stimulus: release RST, then START=1.
  - Required: restarts cleanly at PC=0.
